cfg_counter: RTL and testbench
==============================

# cfg_counter

Parametrised up/down counter that generalises the team's free-running output counter with a programmable prescaler, synchronous load, wrap or saturate limiting, a sticky overflow flag and an optional compare-match pulse. It sits between the top-level tile wrapper and its output pins, or feeds other blocks a divided timebase. All outputs are registered.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (≥2)
- PRESCALE_W, 4, prescaler setting width (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous and active-high
- en  in  1  count enable; gates the prescaler
- dir  in  1  1 = count up, 0 = count down
- sat  in  1  1 = saturate at limit, 0 = wrap around
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  value to load
- prescale  in  PRESCALE_W  one step every prescale+1 enabled cycles
- clr_ovf  in  1  clears ovf
- cmp_val  in  WIDTH  compare value; used only with CFG_COUNTER_CMP_EN
- count  out  WIDTH  current count
- tick  out  1  1-cycle pulse, count stepped this cycle
- limit  out  1  1-cycle pulse, a step hit a boundary (wrapped or clamped)
- ovf  out  1  sticky limit flag
- match  out  1  1-cycle compare-match pulse

## Operation
- Priority per edge: rst > load > step. ovf update is independent.
- rst: count, internal prescaler pre, tick, limit, ovf, match all 0.
- load: count <= load_val, pre <= 0, tick = 0, limit = 0. Applies whether en is high or low.
- Prescaler, en=1 and no load: if pre >= prescale then step, pre <= 0; else pre <= pre+1. The >= comparison ensures a prescale reduction mid-count takes effect without a 2^PRESCALE_W run-out. en=0 holds pre and count and issues no tick.
- Step up, count < max: count+1. Step down, count > 0: count-1.
- Step up at all-ones:
  - sat=0: count <= 0, limit=1.
  - sat=1: count holds all-ones, limit=1.
- Step down at 0:
  - sat=0: count <= all-ones, limit=1.
  - sat=1: count holds 0, limit=1.
- tick=1 on every step, including clamped steps.
- ovf: set when limit asserts; cleared by clr_ovf. Set and clr_ovf in the same cycle leaves ovf=1 (set wins).
- dir and sat are sampled on each step edge and can change at any time.
- match, with the macro: asserts when the count value being written by a step or a load equals cmp_val. It does not assert on a clamped step that leaves count unchanged. It does not assert while count merely sits at cmp_val.

## Timing
- One register stage. count, tick, limit and match change on the same edge.
- prescale=0 with en held high: count steps every cycle. First new value appears at the first edge after en=1 is sampled.
- prescale=N: steps are spaced N+1 enabled cycles apart. After a load, the first step lands N+1 enabled cycles later.
- ovf rises on the same edge as limit. It falls on the edge after clr_ovf is sampled, provided limit does not also assert on that edge.
- rst asserted mid-count: all outputs read 0 after the next edge, regardless of en, load or clr_ovf.

## Configuration
- CFG_COUNTER_CMP_EN defined: compare logic is built and match operates as specified.
- CFG_COUNTER_CMP_EN undefined: match is tied 0, cmp_val is unused, and no compare hardware is present. The port list is identical in both builds.

## Test plan
- Reset, then en=1, dir=1, sat=0, prescale=0 for 260 cycles -> count 0,1,…,255,0,…; limit and tick both pulse on the 255→0 edge; ovf=1 afterwards; clr_ovf one cycle -> ovf=0.
- prescale=3, en=1 -> tick every 4th cycle. Drop en for 5 cycles mid-period -> count and pre frozen; period resumes where it stopped.
- load_val=0x02, then dir=0, sat=1 -> count 1, 0, 0, 0 with limit pulsing on each clamped step. Same sequence with sat=0 -> count 1, 0, 0xFF.
- load asserted in the same cycle a step is due (load_val=0x80) -> count=0x80, tick=0, next step N+1 enabled cycles later. clr_ovf on the same cycle as limit -> ovf stays 1.
- CFG_COUNTER_CMP_EN, cmp_val=0x05, counting up from 0 -> single match pulse on the edge count becomes 5. Load of 0x05 -> match pulse. Holding with en=0 -> no further pulses. Macro undefined -> match constantly 0.
- rst asserted while count=0x37, ovf=1, load=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/cfg_counter.sv
// rtl/cfg_counter.sv - prescaled up/down counter with wrap/saturate limiting and sticky overflow
// Compare-match pulse is built only when CFG_COUNTER_CMP_EN is defined; otherwise match is tied 0.
module cfg_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  sat,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clr_ovf,
  input  logic [WIDTH-1:0]      cmp_val,
  output logic [WIDTH-1:0]      count,
  output logic                  tick,
  output logic                  limit,
  output logic                  ovf,
  output logic                  match
);

  logic [WIDTH-1:0]      r_count;
  logic [PRESCALE_W-1:0] r_pre;
  logic                  r_tick;
  logic                  r_limit;
  logic                  r_ovf;
  logic                  r_match;

  logic                  w_step;
  logic                  w_at_bound;
  logic                  w_clamp;
  logic [WIDTH-1:0]      w_count_inc;
  logic [WIDTH-1:0]      w_step_val;
  logic [WIDTH-1:0]      w_count_nxt;
  logic [PRESCALE_W-1:0] w_pre_nxt;
  logic                  w_limit_nxt;
  logic                  w_ovf_nxt;
  logic                  w_match_nxt;

  always_comb begin
    w_step      = 1'b0;
    w_at_bound  = 1'b0;
    w_clamp     = 1'b0;
    w_count_inc = r_count;
    w_step_val  = r_count;
    w_count_nxt = r_count;
    w_pre_nxt   = r_pre;
    w_limit_nxt = 1'b0;
    w_ovf_nxt   = r_ovf;

    // >= rather than == so lowering prescale mid-period steps immediately
    w_step      = en && !load && (r_pre >= prescale);
    w_at_bound  = dir ? (r_count == {WIDTH{1'b1}}) : (r_count == {WIDTH{1'b0}});
    w_clamp     = w_at_bound && sat;
    // Natural modular +/-1 already yields the wrap value at either boundary
    w_count_inc = dir ? (r_count + 1'b1) : (r_count - 1'b1);
    w_step_val  = w_clamp ? r_count : w_count_inc;

    if (load) begin
      w_count_nxt = load_val;
      w_pre_nxt   = '0;
    end else if (en) begin
      if (w_step) begin
        w_count_nxt = w_step_val;
        w_pre_nxt   = '0;
      end else begin
        w_pre_nxt   = r_pre + 1'b1;
      end
    end

    w_limit_nxt = w_step && w_at_bound;
    w_ovf_nxt   = w_limit_nxt || (r_ovf && !clr_ovf);
  end

`ifdef CFG_COUNTER_CMP_EN
  always_comb begin
    w_match_nxt = 1'b0;
    if (load) begin
      w_match_nxt = (load_val == cmp_val);
    end else if (w_step && !w_clamp) begin
      w_match_nxt = (w_step_val == cmp_val);
    end
  end
`else
  logic w_unused_cmp;
  assign w_unused_cmp = ^cmp_val;
  assign w_match_nxt  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_pre   <= '0;
      r_tick  <= 1'b0;
      r_limit <= 1'b0;
      r_ovf   <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_pre   <= w_pre_nxt;
      r_tick  <= w_step;
      r_limit <= w_limit_nxt;
      r_ovf   <= w_ovf_nxt;
      r_match <= w_match_nxt;
    end
  end

  assign count = r_count;
  assign tick  = r_tick;
  assign limit = r_limit;
  assign ovf   = r_ovf;
  assign match = r_match;

endmodule

// File: tb/tb_cfg_counter.sv
// tb/tb_cfg_counter.sv - randomized and directed self-checking bench for cfg_counter
module tb_cfg_counter;

  localparam int W   = 8;
  localparam int PW  = 4;
  localparam int MAX = 255;
`ifdef CFG_COUNTER_CMP_EN
  localparam bit CMP_ON = 1'b1;
`else
  localparam bit CMP_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, en, dir, sat, load, clr_ovf;
  logic [W-1:0]  load_val, cmp_val;
  logic [PW-1:0] prescale;
  logic [W-1:0]  count;
  logic          tick, limit, ovf, match;

  int errors = 0;
  int checks = 0;

  int m_count, m_pre;
  bit m_tick, m_limit, m_ovf, m_match;

  logic [7:0] exp_c [2][4] = '{'{8'h01, 8'h00, 8'hFF, 8'hFE}, '{8'h01, 8'h00, 8'h00, 8'h00}};
  logic       exp_l [2][4] = '{'{1'b0, 1'b0, 1'b1, 1'b0}, '{1'b0, 1'b0, 1'b1, 1'b1}};

  always #5 clk = ~clk;

  cfg_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .sat(sat), .load(load),
    .load_val(load_val), .prescale(prescale), .clr_ovf(clr_ovf), .cmp_val(cmp_val),
    .count(count), .tick(tick), .limit(limit), .ovf(ovf), .match(match)
  );

  task automatic model_step();
    int nxt;
    bit keep_ovf;
    if (rst) begin
      m_count = 0; m_pre = 0; m_tick = 0; m_limit = 0; m_ovf = 0; m_match = 0;
    end else begin
      keep_ovf = m_ovf && !clr_ovf;
      m_tick = 0; m_limit = 0; m_match = 0;
      if (load) begin
        m_count = int'(load_val);
        m_pre   = 0;
        m_match = CMP_ON && (load_val == cmp_val);
      end else if (en) begin
        if (m_pre >= int'(prescale)) begin
          m_pre  = 0;
          m_tick = 1;
          nxt    = m_count + (dir ? 1 : -1);
          if (nxt < 0 || nxt > MAX) begin
            m_limit = 1;
            nxt = sat ? m_count : (nxt + MAX + 1) % (MAX + 1);
          end
          m_match = CMP_ON && !(m_limit && sat) && (nxt == int'(cmp_val));
          m_count = nxt;
        end else begin
          m_pre = m_pre + 1;
        end
      end
      m_ovf = keep_ovf || m_limit;
    end
  endtask

  function automatic logic [11:0] model_vec();
    logic [7:0] c;
    c = m_count[7:0];
    return {c, m_tick, m_limit, m_ovf, m_match};
  endfunction

  task automatic tick_clk();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 0; en = 0; dir = 1; sat = 0; load = 0; clr_ovf = 0;
    load_val = '0; prescale = '0; cmp_val = 8'h05;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    tick_clk();
    checks++;
    if ({count, tick, limit, ovf, match} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state got=%h exp=000", {count, tick, limit, ovf, match});
    end
    rst = 0;
  endtask

  task automatic test_wrap_up();
    logic [7:0] e;
    set_idle();
    en = 1;
    for (int i = 1; i <= 260; i++) begin
      tick_clk();
      e = 8'(i % 256);
      checks++;
      if (count !== e || tick !== 1'b1 || limit !== (i == 256)) begin
        errors++;
        $display("FAIL wrap_seq i=%0d got count=%h tick=%b limit=%b exp count=%h tick=1 limit=%b",
                 i, count, tick, limit, e, (i == 256));
      end
      checks++;
      if ({count, tick, limit, ovf, match} !== model_vec()) begin
        errors++;
        $display("FAIL wrap_model i=%0d got=%h exp=%h", i, {count, tick, limit, ovf, match}, model_vec());
      end
    end
    en = 0;
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL wrap_ovf_set got=%b exp=1", ovf);
    end
    clr_ovf = 1;
    tick_clk();
    clr_ovf = 0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL wrap_ovf_clr got=%b exp=0", ovf);
    end
  endtask

  task automatic test_prescale();
    set_idle();
    rst = 1;
    tick_clk();
    rst = 0; en = 1; prescale = 4'd3;
    for (int k = 1; k <= 10; k++) begin
      tick_clk();
      checks++;
      if (tick !== (k % 4 == 0) || count !== 8'(k / 4)) begin
        errors++;
        $display("FAIL prescale_run k=%0d got tick=%b count=%h exp tick=%b count=%h",
                 k, tick, count, (k % 4 == 0), 8'(k / 4));
      end
    end
    for (int k = 0; k < 9; k++) begin
      en = (k >= 5);
      tick_clk();
      checks++;
      if ({count, tick, limit, ovf, match} !== model_vec()) begin
        errors++;
        $display("FAIL prescale_pause k=%0d got=%h exp=%h", k, {count, tick, limit, ovf, match}, model_vec());
      end
    end
    checks++;
    if (count !== 8'h03) begin
      errors++;
      $display("FAIL prescale_resume got count=%h exp=03", count);
    end
  endtask

  task automatic test_clamp();
    for (int s = 0; s < 2; s++) begin
      set_idle();
      sat = s[0]; dir = 0; en = 1; load = 1; load_val = 8'h02;
      tick_clk();
      load = 0;
      for (int j = 0; j < 4; j++) begin
        tick_clk();
        checks++;
        if (count !== exp_c[s][j] || limit !== exp_l[s][j] || tick !== 1'b1) begin
          errors++;
          $display("FAIL clamp sat=%0d j=%0d got count=%h limit=%b tick=%b exp count=%h limit=%b tick=1",
                   s, j, count, limit, tick, exp_c[s][j], exp_l[s][j]);
        end
        checks++;
        if ({count, tick, limit, ovf, match} !== model_vec()) begin
          errors++;
          $display("FAIL clamp_model sat=%0d j=%0d got=%h exp=%h", s, j, {count, tick, limit, ovf, match}, model_vec());
        end
      end
    end
  endtask

  task automatic test_load_collision();
    set_idle();
    rst = 1;
    tick_clk();
    rst = 0; en = 1; prescale = 4'd2;
    tick_clk();
    tick_clk();
    load = 1; load_val = 8'h80;
    tick_clk();
    load = 0;
    checks++;
    if (count !== 8'h80 || tick !== 1'b0) begin
      errors++;
      $display("FAIL load_collide got count=%h tick=%b exp count=80 tick=0", count, tick);
    end
    for (int k = 1; k <= 3; k++) begin
      tick_clk();
      checks++;
      if (tick !== (k == 3) || count !== ((k == 3) ? 8'h81 : 8'h80)) begin
        errors++;
        $display("FAIL load_next_step k=%0d got count=%h tick=%b exp tick=%b", k, count, tick, (k == 3));
      end
    end
    prescale = 4'd0; load = 1; load_val = 8'hFF; clr_ovf = 1;
    tick_clk();
    load = 0;
    tick_clk();
    checks++;
    if (limit !== 1'b1 || ovf !== 1'b1 || count !== 8'h00) begin
      errors++;
      $display("FAIL clr_vs_limit got limit=%b ovf=%b count=%h exp limit=1 ovf=1 count=00", limit, ovf, count);
    end
    en = 0;
    tick_clk();
    clr_ovf = 0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL clr_after_limit got ovf=%b exp=0", ovf);
    end
  endtask

  task automatic test_match();
    set_idle();
    rst = 1;
    tick_clk();
    rst = 0; en = 1; cmp_val = 8'h05;
    for (int k = 1; k <= 9; k++) begin
      en = (k <= 5);
      tick_clk();
      checks++;
      if (match !== (CMP_ON && k == 5)) begin
        errors++;
        $display("FAIL match_count k=%0d got=%b exp=%b", k, match, (CMP_ON && k == 5));
      end
    end
    load = 1; load_val = 8'h05;
    tick_clk();
    load = 0;
    checks++;
    if (match !== CMP_ON) begin
      errors++;
      $display("FAIL match_load got=%b exp=%b", match, CMP_ON);
    end
    for (int k = 0; k < 3; k++) begin
      tick_clk();
      checks++;
      if (match !== 1'b0 || count !== 8'h05) begin
        errors++;
        $display("FAIL match_hold k=%0d got match=%b count=%h exp match=0 count=05", k, match, count);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_idle();
    en = 1; load = 1; load_val = 8'hFF;
    tick_clk();
    load = 0;
    tick_clk();
    load = 1; load_val = 8'h37; en = 0;
    tick_clk();
    checks++;
    if (count !== 8'h37 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_setup got count=%h ovf=%b exp count=37 ovf=1", count, ovf);
    end
    rst = 1; en = 1; load = 1; load_val = 8'h55;
    tick_clk();
    rst = 0; load = 0; en = 0;
    checks++;
    if ({count, tick, limit, ovf, match} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=000", {count, tick, limit, ovf, match});
    end
  endtask

  task automatic test_random();
    set_idle();
    for (int k = 0; k < 1500; k++) begin
      rst      = ($urandom_range(0, 99) == 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom);
      en       = ($urandom_range(0, 3) != 0);
      dir      = ($urandom_range(0, 3) != 0);
      sat      = ($urandom_range(0, 1) == 1);
      clr_ovf  = ($urandom_range(0, 7) == 0);
      cmp_val  = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) prescale = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 9) == 0) prescale = 4'($urandom_range(0, 2));
      tick_clk();
      checks++;
      if ({count, tick, limit, ovf, match} !== model_vec()) begin
        errors++;
        $display("FAIL random k=%0d got=%h exp=%h", k, {count, tick, limit, ovf, match}, model_vec());
      end
    end
  endtask

  initial begin
    set_idle();
    m_count = 0; m_pre = 0; m_tick = 0; m_limit = 0; m_ovf = 0; m_match = 0;
    @(negedge clk);
    test_reset();
    test_wrap_up();
    test_prescale();
    test_clamp();
    test_load_collision();
    test_match();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
